alu_issue_unit: RTL and testbench
=================================

// Module: alu_issue_unit
// PURPOSE
//  Front end of the ALU datapath: accepts 16-bit instructions over a valid/ready handshake, splits
//  them into op_code/instr_type/operands for alu_control + alu, and sequences operand read, execute,
//  and writeback. Captures ALU flags into a registered PSR and feeds PSR.C back as ALU carry_in.
//  Sits between fetch and the register file / ALU pair.
// PARAMETERS
//  WIDTH_DATA    16  datapath and instruction width
//  WIDTH_REG     4   register address width (16 GPRs)
//  WIDTH_OP_CODE 4   op_code width driven to alu_control
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  reset_n       in   1   synchronous, active-low reset
//  instr         in   16  instruction word; sampled when instr_valid & instr_ready
//  instr_valid   in   1   fetch has an instruction
//  instr_ready   out  1   unit is idle and will accept
//  rf_addr_a     out  4   read port A address (Rdest)
//  rf_addr_b     out  4   read port B address (Rsrc)
//  rf_data_a     in   16  combinational read data A
//  rf_data_b     in   16  combinational read data B
//  alu_op_code   out  4   to alu_control.op_code
//  alu_instr_type out 1   to alu_control.instr_type (0 static, 1 shift)
//  alu_a, alu_b  out  16  ALU operands (A = Rdest value, B = Rsrc value or extended immediate)
//  alu_carry_in  out  1   = psr[C]
//  alu_result    in   16  ALU result
//  alu_flags     in   5   {carry,low,over,neg,zero} from ALU
//  wb_en         out  1   one-cycle register write strobe
//  wb_addr       out  4   write register
//  wb_data       out  16  write data
//  psr           out  5   registered {C,L,F,N,Z}
//  illegal       out  1   one-cycle pulse on undecodable instruction
// BEHAVIOUR
//  Format: [15:12] op, [11:8] Rdest, [7:4] opext, [3:0] Rsrc/imm.
//   op=0000 register form: op_code=opext, B=rf_data_b, type 0.
//   op=1000 shift: type 1; opext 0100/0110 register amount; opext 000s immediate, B=sext({s,imm[3:0]}).
//   any other op: immediate form, op_code=op, B=imm[7:0] sign-extended; AND/OR/XOR zero-extend.
//  Legal static op_codes: 0001,0010,0011,0101,0110,0111,1001,1010,1011; others -> illegal.
//  FSM: IDLE -> READ -> EXEC -> WB -> IDLE. instr_ready=1 only in IDLE.
//   IDLE: on instr_valid, latch instr, go READ. READ: register rf_data_a/b and extended imm.
//   EXEC: drive alu_* from registers; capture alu_result and alu_flags. WB: wb_en=1 one cycle, PSR update.
//  Latency: accept edge -> wb_en asserted 3 cycles later; throughput 1 instr / 4 cycles; no overlap.
//  alu_* outputs held stable for all of EXEC; op_code/type driven from latched instr in all states.
//  PSR update masks (WB): ADD/ADDU/ADDC/SUB/SUBC -> C,F; CMP -> L,N,Z; logic/shift -> none.
//  CMP: no writeback (wb_en stays 0) but PSR updates. Illegal: detected in READ, pulse illegal,
//   return to IDLE directly, no wb_en, PSR unchanged.
//  alu_carry_in reflects PSR before the current instruction's own update (ADDC chains correctly).
//  Reset (any state, incl. mid-instruction): state=IDLE, instr_ready=1 next cycle, wb_en=0, illegal=0,
//   psr=0, wb_addr/wb_data/alu_a/alu_b=0, latched instr=0; in-flight instruction discarded.
//  instr_valid while not ready: ignored, fetch must hold.
// STRUCTURE
//  Shared package alu_pkg: OP_CODE_*, CONTROL_*, INSTR_STATIC/INSTR_SHIFT, PSR bit indices, state enum.
//  One sub-module: instr_field_decode (combinational: legality, form, immediate extension, PSR mask).
//  FSM and operand/result registers stay in alu_issue_unit.
// TESTING
//  ADD R1,R2 with R1=0x0005,R2=0x0003 -> wb_en 3 cycles after accept, wb_addr=1, wb_data=0x0008, psr=0.
//  ADD 0x7FFF+0x0001 then ADDC with psr.C preset -> first sets F=1; ADDC drives alu_carry_in=1.
//  CMP R3,R4 with 0x0002 vs 0x0009 -> no wb_en, psr L=1 and N per ALU, C/F preserved.
//  Immediate ANDI 0xFF on 0x1234 -> alu_b=0x00FF (zero-ext); ADDI 0xFF -> alu_b=0xFFFF.
//  Shift imm opext 0001 imm 0xF (-1) on 0x8000 -> alu_b=0xFFFF, instr_type=1, wb_data per ALU right shift.
//  Illegal op 1111 -> illegal pulse, no wb_en, psr unchanged; reset_n low during EXEC -> IDLE, no wb_en.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU front end: op codes, instruction types,
// PSR bit positions and the issue FSM state type.
package alu_pkg;

  localparam int PSR_W = 5;

  // Major op field values that select the instruction format
  localparam logic [3:0] OP_CODE_REG   = 4'b0000;
  localparam logic [3:0] OP_CODE_SHIFT = 4'b1000;

  // alu_control op codes for static instructions
  localparam logic [3:0] CONTROL_AND  = 4'b0001;
  localparam logic [3:0] CONTROL_OR   = 4'b0010;
  localparam logic [3:0] CONTROL_XOR  = 4'b0011;
  localparam logic [3:0] CONTROL_ADD  = 4'b0101;
  localparam logic [3:0] CONTROL_ADDU = 4'b0110;
  localparam logic [3:0] CONTROL_ADDC = 4'b0111;
  localparam logic [3:0] CONTROL_SUB  = 4'b1001;
  localparam logic [3:0] CONTROL_SUBC = 4'b1010;
  localparam logic [3:0] CONTROL_CMP  = 4'b1011;

  // Shift op extensions with a register-supplied amount
  localparam logic [3:0] CONTROL_LSH  = 4'b0100;
  localparam logic [3:0] CONTROL_ASHU = 4'b0110;

  localparam logic INSTR_STATIC = 1'b0;
  localparam logic INSTR_SHIFT  = 1'b1;

  // PSR layout {C,L,F,N,Z}, same ordering as the ALU flag bus
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic is_static_legal(input logic [3:0] code);
    case (code)
      CONTROL_AND, CONTROL_OR, CONTROL_XOR,
      CONTROL_ADD, CONTROL_ADDU, CONTROL_ADDC,
      CONTROL_SUB, CONTROL_SUBC, CONTROL_CMP: is_static_legal = 1'b1;
      default:                                is_static_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction field decode: op code / type selection,
// legality, immediate extension and which PSR bits the instruction updates.
module instr_field_decode
  import alu_pkg::*;
(
  input  logic [15:0]      instr,
  output logic [3:0]       op_code,
  output logic             instr_type,
  output logic             legal,
  output logic             use_imm,
  output logic [15:0]      imm_ext,
  output logic [PSR_W-1:0] psr_mask,
  output logic             is_cmp
);

  logic [3:0] op;
  logic [3:0] opext;

  assign op    = instr[15:12];
  assign opext = instr[7:4];

  // Select format, operand source and immediate extension from the op field
  always_comb begin
    op_code    = op;
    instr_type = INSTR_STATIC;
    use_imm    = 1'b1;
    imm_ext    = {{8{instr[7]}}, instr[7:0]};
    legal      = 1'b0;
    if (op == OP_CODE_REG) begin
      op_code = opext;
      use_imm = 1'b0;
      legal   = is_static_legal(opext);
    end else if (op == OP_CODE_SHIFT) begin
      instr_type = INSTR_SHIFT;
      op_code    = opext;
      if (opext == CONTROL_LSH || opext == CONTROL_ASHU) begin
        use_imm = 1'b0;
        legal   = 1'b1;
      end else if (opext[3:1] == 3'b000) begin
        // opext[0] is the sign bit of a 5-bit signed shift amount
        imm_ext = {{11{opext[0]}}, opext[0], instr[3:0]};
        legal   = 1'b1;
      end
    end else begin
      legal = is_static_legal(op);
      if (op == CONTROL_AND || op == CONTROL_OR || op == CONTROL_XOR)
        imm_ext = {8'h00, instr[7:0]};
    end
  end

  // Flags an instruction is allowed to write into the PSR
  always_comb begin
    psr_mask = '0;
    is_cmp   = 1'b0;
    if (instr_type == INSTR_STATIC) begin
      case (op_code)
        CONTROL_ADD, CONTROL_ADDU, CONTROL_ADDC, CONTROL_SUB, CONTROL_SUBC: begin
          psr_mask[PSR_C] = 1'b1;
          psr_mask[PSR_F] = 1'b1;
        end
        CONTROL_CMP: begin
          psr_mask[PSR_L] = 1'b1;
          psr_mask[PSR_N] = 1'b1;
          psr_mask[PSR_Z] = 1'b1;
          is_cmp          = 1'b1;
        end
        default: psr_mask = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU front end: accepts one instruction at a time, reads operands, runs the
// external ALU, writes back the result and maintains the PSR.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_REG     = 4,
  parameter int WIDTH_OP_CODE = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH_DATA-1:0]    instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  output logic [WIDTH_REG-1:0]     rf_addr_a,
  output logic [WIDTH_REG-1:0]     rf_addr_b,
  input  logic [WIDTH_DATA-1:0]    rf_data_a,
  input  logic [WIDTH_DATA-1:0]    rf_data_b,
  output logic [WIDTH_OP_CODE-1:0] alu_op_code,
  output logic                     alu_instr_type,
  output logic [WIDTH_DATA-1:0]    alu_a,
  output logic [WIDTH_DATA-1:0]    alu_b,
  output logic                     alu_carry_in,
  input  logic [WIDTH_DATA-1:0]    alu_result,
  input  logic [PSR_W-1:0]         alu_flags,
  output logic                     wb_en,
  output logic [WIDTH_REG-1:0]     wb_addr,
  output logic [WIDTH_DATA-1:0]    wb_data,
  output logic [PSR_W-1:0]         psr,
  output logic                     illegal
);

  state_t                  state;
  logic [WIDTH_DATA-1:0]   instr_q;
  logic [WIDTH_DATA-1:0]   res_q;
  logic [PSR_W-1:0]        flags_q;

  logic [3:0]              dec_op_code;
  logic                    dec_type;
  logic                    dec_legal;
  logic                    dec_use_imm;
  logic [15:0]             dec_imm_ext;
  logic [PSR_W-1:0]        dec_psr_mask;
  logic                    dec_is_cmp;

  instr_field_decode u_decode (
    .instr      (instr_q),
    .op_code    (dec_op_code),
    .instr_type (dec_type),
    .legal      (dec_legal),
    .use_imm    (dec_use_imm),
    .imm_ext    (dec_imm_ext),
    .psr_mask   (dec_psr_mask),
    .is_cmp     (dec_is_cmp)
  );

  assign rf_addr_a      = instr_q[8 +: WIDTH_REG];
  assign rf_addr_b      = instr_q[0 +: WIDTH_REG];
  assign alu_op_code    = dec_op_code;
  assign alu_instr_type = dec_type;
  assign alu_carry_in   = psr[PSR_C];

  // Issue FSM with operand, result, writeback and PSR registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      instr_q     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      psr         <= '0;
      wb_en       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (!dec_legal) begin
            illegal     <= 1'b1;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            alu_a <= rf_data_a;
            alu_b <= dec_use_imm ? dec_imm_ext : rf_data_b;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q   <= alu_result;
          flags_q <= alu_flags;
          state   <= ST_WB;
        end
        ST_WB: begin
          psr <= (psr & ~dec_psr_mask) | (flags_q & dec_psr_mask);
          if (!dec_is_cmp) begin
            wb_en   <= 1'b1;
            wb_addr <= instr_q[8 +: WIDTH_REG];
            wb_data <= res_q;
          end
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural register file and ALU around the DUT,
// directed instruction vectors, writeback scoreboard checked by a monitor.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic [3:0]  alu_op_code;
  logic        alu_instr_type;
  logic [15:0] alu_a, alu_b;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [4:0]  psr;
  logic        illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          ill;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] regs [16] = '{16'h0000, 16'h0005, 16'h0003, 16'h0002,
                             16'h0009, 16'h7FFF, 16'h0001, 16'h1234,
                             16'h8000, 16'h8000, 16'h0000, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000};

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .rf_addr_a      (rf_addr_a),
    .rf_addr_b      (rf_addr_b),
    .rf_data_a      (rf_data_a),
    .rf_data_b      (rf_data_b),
    .alu_op_code    (alu_op_code),
    .alu_instr_type (alu_instr_type),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_carry_in   (alu_carry_in),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .psr            (psr),
    .illegal        (illegal)
  );

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  always @(posedge clk) begin
    if (wb_en) regs[wb_addr] <= wb_data;
  end

  // Reference ALU: flags {carry,low,over,neg,zero}
  always_comb begin
    logic [16:0] sum;
    logic [15:0] amt;
    sum        = '0;
    amt        = '0;
    alu_result = '0;
    alu_flags  = '0;
    if (alu_instr_type) begin
      if (alu_b[15]) begin
        amt        = ~alu_b + 16'd1;
        alu_result = alu_a >> amt;
      end else begin
        alu_result = alu_a << alu_b;
      end
    end else begin
      case (alu_op_code)
        4'b0101, 4'b0110: sum = {1'b0, alu_a} + {1'b0, alu_b};
        4'b0111:          sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
        4'b1001, 4'b1011: sum = {1'b0, alu_a} - {1'b0, alu_b};
        4'b1010:          sum = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_carry_in};
        4'b0001:          sum = {1'b0, alu_a & alu_b};
        4'b0010:          sum = {1'b0, alu_a | alu_b};
        4'b0011:          sum = {1'b0, alu_a ^ alu_b};
        default:          sum = '0;
      endcase
      alu_result = sum[15:0];
      if (alu_op_code == 4'b1011) begin
        alu_flags[3] = alu_a < alu_b;
        alu_flags[1] = $signed(alu_a) < $signed(alu_b);
        alu_flags[0] = alu_a == alu_b;
      end else begin
        alu_flags[4] = sum[16];
        if (alu_op_code[3])
          alu_flags[2] = (alu_a[15] != alu_b[15]) && (sum[15] != alu_a[15]);
        else
          alu_flags[2] = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
        alu_flags[1] = sum[15];
        alu_flags[0] = sum[15:0] == 16'h0000;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every wb_en or illegal pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && (wb_en || illegal)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: wb_en=%0b illegal=%0b with empty scoreboard", wb_en, illegal);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (!e.ill) begin
          chk("sb_wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
          chk("sb_wb_data", {16'd0, wb_data}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic accept(input logic [15:0] ins);
    @(negedge clk);
    wait_ready();
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Issue one instruction; checks EXEC operands and the cycle-3 writeback/PSR
  task automatic issue(input string name, input logic [15:0] ins, input bit ill,
                       input bit exp_wb, input logic [3:0] waddr, input logic [15:0] wdata,
                       input logic [15:0] exp_b, input bit exp_type, input bit exp_cin,
                       input logic [4:0] exp_psr);
    exp_t e;
    if (ill || exp_wb) begin
      e.ill  = ill;
      e.addr = waddr;
      e.data = wdata;
      exp_q.push_back(e);
    end
    accept(ins);
    @(negedge clk);
    @(negedge clk);
    if (!ill) begin
      chk({name, "_alu_b"}, {16'd0, alu_b}, {16'd0, exp_b});
      chk({name, "_type"}, {31'd0, alu_instr_type}, {31'd0, exp_type});
      chk({name, "_cin"}, {31'd0, alu_carry_in}, {31'd0, exp_cin});
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_wb_en"}, {31'd0, wb_en}, {31'd0, exp_wb});
    chk({name, "_psr"}, {27'd0, psr}, {27'd0, exp_psr});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_psr", {27'd0, psr}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);

    //     name     instr     ill wb addr  data      alu_b     typ cin psr
    issue("add",   16'h0152, 0, 1, 4'd1, 16'h0008, 16'h0003, 0, 0, 5'b00000);
    issue("addovf", 16'h0556, 0, 1, 4'd5, 16'h8000, 16'h0001, 0, 0, 5'b00100);
    issue("addcy", 16'h0858, 0, 1, 4'd8, 16'h0000, 16'h8000, 0, 0, 5'b10100);
    issue("cmp",   16'h03B4, 0, 0, 4'd0, 16'h0000, 16'h0009, 0, 1, 5'b11110);
    issue("addc",  16'h0172, 0, 1, 4'd1, 16'h000C, 16'h0003, 0, 1, 5'b01010);
    issue("andi",  16'h17FF, 0, 1, 4'd7, 16'h0034, 16'h00FF, 0, 0, 5'b01010);
    issue("addi",  16'h51FF, 0, 1, 4'd1, 16'h000B, 16'hFFFF, 0, 0, 5'b11010);
    issue("shifti", 16'h891F, 0, 1, 4'd9, 16'h4000, 16'hFFFF, 1, 1, 5'b11010);
    issue("ill_op", 16'hF000, 1, 0, 4'd0, 16'h0000, 16'h0000, 0, 0, 5'b11010);
    issue("ill_ext", 16'h0104, 1, 0, 4'd0, 16'h0000, 16'h0000, 0, 0, 5'b11010);

    // Reset asserted while the instruction is in EXEC; nothing must be written back
    accept(16'h0152);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_psr", {27'd0, psr}, 32'd0);
    chk("midrst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("midrst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("midrst_wb_en", {31'd0, wb_en}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    issue("add_post", 16'h0152, 0, 1, 4'd1, 16'h000E, 16'h0003, 0, 0, 5'b00000);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
